// File: rtl/conv_output_collector_pkg.sv
// Shared definitions for the conv feeder/collector pair: FSM encodings and lane geometry.
// The feeder uses the same encodings, so keep them in sync.
package conv_output_collector_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int DW  = 16;  // product / pixel width
  localparam int WIN = 3;   // window side: lanes per beat and beats per pixel

endpackage

// File: rtl/conv_output_collector_if.sv
// Beat stream from the feeder plus the collector's feature-map and status outputs.
interface conv_output_collector_if #(parameter int OUT = 12);
  import conv_output_collector_pkg::*;

  logic                    start;
  logic                    pass;
  logic [DW-1:0]           in1;
  logic [DW-1:0]           in2;
  logic [DW-1:0]           in3;
  logic [0:OUT*OUT*DW-1]   fmap_out;
  logic                    busy;
  logic                    done;
  logic                    trunc;
  logic                    ovf;

  modport master (
    output start, pass, in1, in2, in3,
    input  fmap_out, busy, done, trunc, ovf
  );

  modport slave (
    input  start, pass, in1, in2, in3,
    output fmap_out, busy, done, trunc, ovf
  );

endinterface

// File: rtl/conv_output_collector_col_accum.sv
// Sums three lanes per beat into an accumulator; every WIN-th beat presents the pixel sum.
module col_accum
  import conv_output_collector_pkg::*;
#(
  parameter int ACCW = 20
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  output logic          pix_valid,
  output logic [DW-1:0] pix_sum,
  output logic          pix_trunc
);

  logic [ACCW-1:0] acc_reg;
  logic [ACCW-1:0] acc_next;
  logic [1:0]      beat_reg;

  assign acc_next  = acc_reg + ACCW'(in1) + ACCW'(in2) + ACCW'(in3);
  assign pix_valid = en && (beat_reg == 2'(WIN - 1));
  assign pix_sum   = acc_next[DW-1:0];
  assign pix_trunc = |acc_next[ACCW-1:DW];

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      acc_reg  <= '0;
      beat_reg <= '0;
    end else if (en) begin
      if (pix_valid) begin
        acc_reg  <= '0;
        beat_reg <= '0;
      end else begin
        acc_reg  <= acc_next;
        beat_reg <= beat_reg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/conv_output_collector.sv
// Collects 3-beat window sums into a raster-ordered feature map; done when every pixel is written.
module conv_output_collector
  import conv_output_collector_pkg::*;
#(
  parameter int IMG  = 14,
  parameter int PAD  = 0,
  parameter int ACCW = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_output_collector_if.slave  bus
);

  localparam int OUT  = IMG + 2*PAD - 2;
  localparam int NPIX = OUT * OUT;
  localparam int PIXW = $clog2(NPIX + 1);

  logic [1:0]            state_reg;
  logic [PIXW-1:0]       pix_idx_reg;
  logic                  trunc_reg;
  logic                  ovf_reg;
  logic [0:NPIX*DW-1]    fmap_bus;

  logic                  frame_start;
  logic                  accum_en;
  logic                  pix_valid;
  logic [DW-1:0]         pix_sum;
  logic                  pix_trunc;

  // rst_n is active-high despite its name.
  assign frame_start = bus.start && (state_reg != ST_COLLECT);
  assign accum_en    = bus.pass  && (state_reg == ST_COLLECT);

  col_accum #(.ACCW(ACCW)) u_accum (
    .clk       (clk),
    .srst      (rst_n),
    .clear     (frame_start),
    .en        (accum_en),
    .in1       (bus.in1),
    .in2       (bus.in2),
    .in3       (bus.in3),
    .pix_valid (pix_valid),
    .pix_sum   (pix_sum),
    .pix_trunc (pix_trunc)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= ST_IDLE;
      pix_idx_reg <= '0;
      trunc_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // A beat arriving with start is still dropped, so it wins over the clear.
          if (bus.pass)
            ovf_reg <= 1'b1;
          else if (bus.start)
            ovf_reg <= 1'b0;
          if (bus.start) begin
            state_reg   <= ST_COLLECT;
            pix_idx_reg <= '0;
            trunc_reg   <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (pix_valid) begin
            pix_idx_reg <= pix_idx_reg + PIXW'(1);
            trunc_reg   <= trunc_reg | pix_trunc;
            if (pix_idx_reg == PIXW'(NPIX - 1))
              state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
    logic [DW-1:0] pix_reg;

    always_ff @(posedge clk) begin
      if (rst_n || frame_start)
        pix_reg <= '0;
      else if (pix_valid && (pix_idx_reg == PIXW'(gi)))
        pix_reg <= pix_sum;
    end

    assign fmap_bus[gi*DW +: DW] = pix_reg;
  end

  assign bus.fmap_out = fmap_bus;
  assign bus.busy     = (state_reg == ST_COLLECT);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.trunc    = trunc_reg;
  assign bus.ovf      = ovf_reg;

endmodule

// File: tb/tb_conv_output_collector.sv
// Directed + randomized bench for conv_output_collector against a beat-list reference model.
module tb_conv_output_collector;

  localparam int IMG  = 14;
  localparam int OUT  = IMG - 2;
  localparam int NPIX = OUT * OUT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  conv_output_collector_if #(.OUT(OUT)) bus ();

  conv_output_collector #(.IMG(IMG), .PAD(0), .ACCW(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame contents, sticky flags, and beats of the pixel in progress.
  int unsigned exp_pix [NPIX];
  bit          m_coll, m_done, m_trunc, m_ovf;
  int unsigned m_beats [$];
  int          m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int k);
    return bus.fmap_out[k*16 +: 16];
  endfunction

  task automatic model_clear();
    foreach (exp_pix[k]) exp_pix[k] = 0;
    m_beats.delete();
    m_idx   = 0;
    m_trunc = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit ps,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    int unsigned s;
    if (r) begin
      model_clear();
      m_coll = 0; m_done = 0; m_ovf = 0;
    end else if (!m_coll) begin
      if (ps) m_ovf = 1;
      else if (st) m_ovf = 0;
      if (st) begin
        model_clear();
        m_coll = 1; m_done = 0;
      end
    end else if (ps) begin
      m_beats.push_back(a + b + c);
      if (m_beats.size() == 3) begin
        s = m_beats[0] + m_beats[1] + m_beats[2];
        exp_pix[m_idx] = s % 65536;
        if (s > 65535) m_trunc = 1;
        m_beats.delete();
        m_idx++;
        if (m_idx == NPIX) begin
          m_coll = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit ps,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    rst_n = r; bus.start = st; bus.pass = ps;
    bus.in1 = a; bus.in2 = b; bus.in3 = c;
    @(posedge clk);
    #1;
    model_step(r, st, ps, a, b, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    cyc(0, 0, 1, a, b, c);
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < NPIX; k++)
      check($sformatf("%s_pix%0d", tag, k), pix(k), exp_pix[k]);
    check({tag, "_busy"},  bus.busy,  m_coll);
    check({tag, "_done"},  bus.done,  m_done);
    check({tag, "_trunc"}, bus.trunc, m_trunc);
    check({tag, "_ovf"},   bus.ovf,   m_ovf);
  endtask

  initial begin
    bus.start = 0; bus.pass = 0; bus.in1 = 0; bus.in2 = 0; bus.in3 = 0;

    // T1: reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    compare_all("t1");
    check("t1_fmap_zero", (bus.fmap_out == '0), 1);
    $display("T1 reset: busy=%0b done=%0b trunc=%0b ovf=%0b", bus.busy, bus.done, bus.trunc, bus.ovf);

    // T6a: stray beat in IDLE
    beat(16'd7, 16'd7, 16'd7);
    check("t6_idle_ovf", bus.ovf, 1);
    check("t6_idle_nopix", pix(0), 0);
    check("t6_idle_busy", bus.busy, 0);
    $display("T6 stray beat in IDLE: ovf=%0b pix0=%0d", bus.ovf, pix(0));

    // T2: single pixel; start clears ovf
    cyc(0, 1, 0, 0, 0, 0);
    check("t2_ovf_cleared", bus.ovf, 0);
    check("t2_busy", bus.busy, 1);
    beat(1, 2, 3);
    beat(4, 5, 6);
    check("t2_pix0_not_yet", pix(0), 0);
    beat(7, 8, 9);
    check("t2_pix0", pix(0), 45);
    check("t2_pix_idx", dut.pix_idx_reg, 1);
    compare_all("t2");
    $display("T2 single pixel: pix0=%0d pix_idx=%0d", pix(0), dut.pix_idx_reg);

    // T3: full frame of (1,1,1) with random gaps; start in COLLECT ignored
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3*NPIX; i++) begin
      idle($urandom_range(0, 2));
      if (i == 100) begin
        cyc(0, 1, 0, 0, 0, 0);
        check("t6_start_ignored_idx", dut.pix_idx_reg, m_idx);
        check("t6_start_ignored_beat", dut.u_accum.beat_reg, m_beats.size());
        check("t6_start_ignored_busy", bus.busy, 1);
      end
      if (i == 3*NPIX - 1) begin
        check("t3_done_before_last", bus.done, 0);
        check("t3_busy_before_last", bus.busy, 1);
      end
      beat(1, 1, 1);
    end
    check("t3_done", bus.done, 1);
    check("t3_busy", bus.busy, 0);
    for (int k = 0; k < NPIX; k++) check($sformatf("t3_pix%0d_nine", k), pix(k), 9);
    compare_all("t3");
    $display("T3 full frame: done=%0b busy=%0b pix143=%0d", bus.done, bus.busy, pix(NPIX-1));

    // T6b: stray beat in DONE leaves the frame intact
    beat(16'd5, 16'd5, 16'd5);
    compare_all("t6_done_stray");
    $display("T6 stray beat in DONE: ovf=%0b done=%0b", bus.ovf, bus.done);

    // T6c + T4: start with pass drops the beat, then a truncating pixel
    cyc(0, 1, 1, 16'd3, 16'd3, 16'd3);
    check("t6_startpass_ovf", bus.ovf, 1);
    check("t6_startpass_beat", dut.u_accum.beat_reg, 0);
    check("t6_startpass_pix0", pix(0), 0);
    for (int i = 0; i < 3; i++) beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("t4_pix0", pix(0), 16'hFFF7);
    check("t4_trunc", bus.trunc, 1);
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 1));
      beat(16'($urandom_range(0, 100)), 16'($urandom_range(0, 100)), 16'($urandom_range(0, 100)));
    end
    check("t4_trunc_sticky", bus.trunc, 1);
    compare_all("t4");
    $display("T4 truncation: pix0=%0h trunc=%0b", pix(0), bus.trunc);

    // Randomized full frame with full-range products, via DONE->start
    for (int i = 0; i < 3*NPIX - 33; i++) beat(16'($urandom), 16'($urandom), 16'($urandom));
    check("rnd1_done", bus.done, 1);
    cyc(0, 1, 0, 0, 0, 0);
    check("rnd_restart_trunc", bus.trunc, 0);
    check("rnd_restart_pix0", pix(0), 0);
    for (int i = 0; i < 3*NPIX; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      beat(16'($urandom_range(0, 21845)), 16'($urandom_range(0, 21845)), 16'($urandom_range(0, 21845)));
      if (i % 97 == 0) compare_all($sformatf("rnd_mid%0d", i));
    end
    compare_all("rnd_frame");
    $display("Random frame: done=%0b trunc=%0b pix7=%0d", bus.done, bus.trunc, pix(7));

    // T5: reset mid-frame after 50 beats
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) beat(16'($urandom), 16'($urandom), 16'($urandom));
    cyc(1, 0, 1, 16'd1, 16'd1, 16'd1);
    check("t5_fmap_zero", (bus.fmap_out == '0), 1);
    compare_all("t5_reset");
    cyc(0, 1, 0, 0, 0, 0);
    beat(1, 2, 3);
    beat(4, 5, 6);
    beat(7, 8, 9);
    check("t5_pix0", pix(0), 45);
    compare_all("t5_after");
    $display("T5 mid-frame reset: pix0=%0d busy=%0b", pix(0), bus.busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
